// File: rtl/avalon_ocram_slave.sv
// Avalon-MM responder backed by a 2**ADDR_W x DATA_W on-chip RAM with programmable wait states.
// Writes to EXPORT_ADDR also drive the low byte onto an 8-bit conduit.
module avalon_ocram_slave #(
  parameter int unsigned         ADDR_W      = 10,
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0]   EXPORT_ADDR = 10'h3FF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [DATA_W-1:0] avs_s0_writedata,
  output logic [DATA_W-1:0] avs_s0_readdata,
  output logic              avs_s0_waitrequest,
  output logic [7:0]        conduit_export
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_read_q;
  logic              op_write_q;
  logic [DATA_W-1:0] rd_buf_q;
  logic [DATA_W-1:0] readdata_q;
  logic              wait_q;
  logic [7:0]        export_q;
  logic              req;
  logic              ack_read;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign req = avs_s0_read | avs_s0_write;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req) state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
      S_WAIT: begin
        if (!req)             state_d = S_IDLE;
        else if (cnt_q <= 4'd1) state_d = S_ACK;
      end
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the op is not latched yet when entering ACK, so take it from the bus.
  assign ack_read = (state_d == S_ACK) &&
                    ((state_q == S_IDLE) ? avs_s0_read : op_read_q);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wait_q     <= 1'b1;
      readdata_q <= '0;
      export_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_d != S_ACK);
      if (state_q == S_IDLE && req)
        cnt_q <= 4'(WAIT_STATES);
      else if (state_q == S_WAIT)
        cnt_q <= cnt_q - 4'd1;
      if (ack_read)
        readdata_q <= (state_q == S_IDLE) ? mem[avs_s0_address] : rd_buf_q;
      if (state_q == S_ACK && op_write_q && addr_q == EXPORT_ADDR)
        export_q <= wdata_q[7:0];
    end
  end

  // Request capture and RAM port; contents survive reset, but a write pending at reset is dropped.
  always_ff @(posedge clk_clk) begin
    if (state_q == S_IDLE) begin
      rd_buf_q <= mem[avs_s0_address];
      if (req) begin
        addr_q     <= avs_s0_address;
        wdata_q    <= avs_s0_writedata;
        op_read_q  <= avs_s0_read;
        op_write_q <= avs_s0_write & ~avs_s0_read;
      end
    end
    if (!reset_reset && state_q == S_ACK && op_write_q)
      mem[addr_q] <= wdata_q;
  end

  assign avs_s0_readdata    = readdata_q;
  assign avs_s0_waitrequest = wait_q;
  assign conduit_export     = export_q;

endmodule
